uart_tx_ctrl: RTL and testbench

//  Sequencing controller for the UART transmit path. Accepts one parallel

---
 rtl/uart_tx_ctrl.sv | 103 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames one latched word as start, data (LSB first),
// optional parity and stop bits, each held for CLKS_PER_BIT clock cycles.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q;
  logic                  bit_end;

  // Request semantics: data_valid is a one-sided request with no ready. It is
  // sampled only in IDLE (busy=0); a high data_valid there is accepted on that
  // edge, and any value presented while busy=1 is ignored.

  assign bit_end = (clk_cnt == CLK_LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (data_valid) state_next = S_START;
      S_START:  if (bit_end) state_next = S_DATA;
      S_DATA:   if (bit_end && (bit_cnt == BIT_LAST))
                  state_next = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (bit_end) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == S_STOP) && bit_end;
      // Restart the bit timer at every bit boundary and on any state change.
      if (bit_end || (state == S_IDLE) || (state_next != state))
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + CW'(1);
      if ((state == S_IDLE) && data_valid) begin
        shift_reg <= p_data;
        par_en_q  <= par_en;
        par_bit   <= (^p_data) ^ par_typ;
        bit_cnt   <= '0;
      end else if ((state == S_DATA) && bit_end) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    mux_sel = 2'b01;
    case (state)
      S_START:  mux_sel = 2'b00;
      S_DATA:   mux_sel = 2'b10;
      S_PARITY: mux_sel = 2'b11;
      default:  mux_sel = 2'b01;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign ser_data  = shift_reg[0];
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-level model expands each accepted word into
// the per-cycle line activity it should produce, compared every cycle.
module tb_uart_tx_ctrl;

  localparam int DW  = 8;
  localparam int CPB = 4;
  // Per-cycle expectation packed as {busy, done, mux_sel[1:0], line_bit}.
  localparam logic [4:0] IDLE_V = 5'b0_0_01_0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [1:0]    mux_sel;
  logic          ser_data, par_bit, busy, done;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_bad = 0;
  int model_done = 0;
  int dut_done = 0;
  bit check_en = 1'b0;

  logic [4:0] exp_q[$];
  logic [4:0] cur = IDLE_V;
  logic [4:0] obs;
  logic       obs_bit;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .p_data(p_data),
    .par_en(par_en), .par_typ(par_typ), .mux_sel(mux_sel), .ser_data(ser_data),
    .par_bit(par_bit), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand one accepted word into its frame, straight from the line format.
  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    for (int c = 0; c < CPB; c++) exp_q.push_back(5'b1_0_00_0);
    for (int i = 0; i < DW; i++)
      for (int c = 0; c < CPB; c++) exp_q.push_back({3'b1_0_1, 1'b0, d[i]});
    if (pe)
      for (int c = 0; c < CPB; c++) exp_q.push_back({3'b1_0_1, 1'b1, (^d) ^ pt});
    for (int c = 0; c < CPB; c++) exp_q.push_back(5'b1_0_01_0);
    exp_q.push_back(5'b0_1_01_0);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur = IDLE_V;
    end else begin
      if (!cur[4] && data_valid) push_frame(p_data, par_en, par_typ);
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
      if (cur[3]) model_done++;
    end
  end

  assign obs_bit = (mux_sel == 2'b10) ? ser_data : (mux_sel == 2'b11) ? par_bit : 1'b0;
  assign obs = {busy, done, mux_sel, obs_bit};

  always @(negedge clk) begin
    if (check_en) begin
      check_eq("cycle", {27'd0, obs}, {27'd0, cur});
      if (done) dut_done++;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(negedge clk);
    data_valid = 1'b1;
    p_data = d;
    par_en = pe;
    par_typ = pt;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Scrambles the data/config inputs while waiting, so any use of unlatched
  // values shows up as a line mismatch.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((cur[4] || exp_q.size() > 0) && n < 200) begin
      @(negedge clk);
      p_data = DW'($urandom);
      par_en = 1'($urandom);
      par_typ = 1'($urandom);
      n++;
    end
    if (n >= 200) check_eq("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int gap;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    check_eq("reset_state", {27'd0, obs}, {27'd0, IDLE_V});

    send(8'hA5, 1'b0, 1'b0);
    wait_idle();
    send(8'h03, 1'b1, 1'b0);
    wait_idle();
    send(8'h03, 1'b1, 1'b1);
    wait_idle();

    // Back-to-back: request held through the done cycle.
    @(negedge clk);
    data_valid = 1'b1;
    p_data = 8'h55;
    par_en = 1'b0;
    @(negedge clk);
    p_data = 8'hFF;
    for (int n = 0; n < 100 && !cur[3]; n++) @(negedge clk);
    check_eq("b2b_done_seen", {31'd0, cur[3]}, 32'd1);
    @(negedge clk);
    data_valid = 1'b0;
    check_eq("b2b_second_start", {30'd0, mux_sel}, 32'd0);
    wait_idle();

    // Config and data changed mid-frame must not affect the frame.
    send(8'hA5, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    p_data = 8'h00;
    par_en = 1'b0;
    par_typ = 1'b0;
    wait_idle();

    // Reset during data bit 3.
    send(8'h96, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    check_eq("pre_rst_mux", {30'd0, mux_sel}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_mid_mux", {30'd0, mux_sel}, 32'd1);
    check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mid_done", {31'd0, done}, 32'd0);
    send(8'h3C, 1'b1, 1'b1);
    wait_idle();

    for (int f = 0; f < 20; f++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      send(DW'($urandom), 1'($urandom), 1'($urandom));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check_eq("done_count", 32'(dut_done), 32'(model_done));
    check_eq("frames_total", 32'(model_done), 32'd27);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
